// File: rtl/st_pkt_arb2.sv
// Two-input Avalon-ST packet arbiter: round-robin grant per packet, combinational
// pass-through of the granted sink, per-input packet counters and a discard counter.
module st_pkt_arb2 #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [1:0]       in0_empty,
   input  logic             in0_startofpacket,
   input  logic             in0_endofpacket,
   input  logic [31:0]      in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [1:0]       in1_empty,
   input  logic             in1_startofpacket,
   input  logic             in1_endofpacket,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_empty,
   output logic             out_startofpacket,
   output logic             out_endofpacket,
   output logic             out_channel,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t         state;
   logic           last_grant;
   logic           req0, req1;
   logic           disc0, disc1;
   logic           xfer;
   logic [1:0]     n_disc;
   logic [ERR_W:0] err_sum;

   // Outputs are gated by rst so nothing is handshaked while reset is asserted.
   always_comb begin
      out_data          = '0;
      out_empty         = '0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_valid         = 1'b0;
      out_channel       = 1'b0;
      in0_ready         = 1'b0;
      in1_ready         = 1'b0;
      disc0             = 1'b0;
      disc1             = 1'b0;
      req0              = in0_valid && in0_startofpacket;
      req1              = in1_valid && in1_startofpacket;
      if (!rst) begin
         case (state)
            IDLE: begin
               disc0     = in0_valid && !in0_startofpacket;
               disc1     = in1_valid && !in1_startofpacket;
               in0_ready = disc0;
               in1_ready = disc1;
            end
            GRANT0: begin
               out_data          = in0_data;
               out_empty         = in0_empty;
               out_startofpacket = in0_startofpacket;
               out_endofpacket   = in0_endofpacket;
               out_valid         = in0_valid;
               in0_ready         = out_ready;
            end
            GRANT1: begin
               out_data          = in1_data;
               out_empty         = in1_empty;
               out_startofpacket = in1_startofpacket;
               out_endofpacket   = in1_endofpacket;
               out_valid         = in1_valid;
               out_channel       = 1'b1;
               in1_ready         = out_ready;
            end
            default: ;
         endcase
      end
      xfer    = out_valid && out_ready;
      n_disc  = {1'b0, disc0} + {1'b0, disc1};
      err_sum = {1'b0, err_cnt} + {{(ERR_W-1){1'b0}}, n_disc};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         pkt_cnt0   <= '0;
         pkt_cnt1   <= '0;
         err_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 && req1)
                  state <= last_grant ? GRANT0 : GRANT1;
               else if (req0)
                  state <= GRANT0;
               else if (req1)
                  state <= GRANT1;
               if (n_disc != 2'd0)
                  err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            end
            GRANT0: begin
               if (xfer && out_endofpacket) begin
                  state      <= IDLE;
                  last_grant <= 1'b0;
                  pkt_cnt0   <= pkt_cnt0 + CNT_W'(1);
               end
            end
            GRANT1: begin
               if (xfer && out_endofpacket) begin
                  state      <= IDLE;
                  last_grant <= 1'b1;
                  pkt_cnt1   <= pkt_cnt1 + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/st_pkt_arb2.md
ST_PKT_ARB2 -- requirements
Module: st_pkt_arb2

Interface
REQ-001 Parameters: CNT_W, 16, packet-counter width; ERR_W, 8, discard-counter width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inN_data (N=0,1)  in  32  Avalon-ST sink data, one sink per requester.
REQ-005 inN_valid  in  1  sink valid.
REQ-006 inN_ready  out  1  sink ready; 0 readLatency.
REQ-007 inN_empty  in  2  sink empty.
REQ-008 inN_startofpacket / inN_endofpacket  in  1 each  packet delimiters.
REQ-009 out_data  out  32  source data, feeds the 32-to-16 width converter.
REQ-010 out_valid / out_ready  out / in  1 each  source handshake; 0 readLatency.
REQ-011 out_empty  out  2  source empty.
REQ-012 out_startofpacket / out_endofpacket  out  1 each  source delimiters.
REQ-013 out_channel  out  1  index of granted input.
REQ-014 pkt_cnt0 / pkt_cnt1  out  CNT_W each  completed packets per input.
REQ-015 err_cnt  out  ERR_W  words discarded outside a packet.

Function
REQ-016 States SHALL be IDLE, GRANT0 and GRANT1, held in a state register.
REQ-017 Request N in IDLE SHALL be inN_valid && inN_startofpacket.
REQ-018 In IDLE with one request, the next state SHALL be GRANTN.
REQ-019 In IDLE with both requests, grant SHALL go to the input not equal to last_grant (round-robin).
REQ-020 In IDLE, out_valid SHALL be 0 and no word SHALL be forwarded; the first packet word transfers no earlier than the cycle after the request (one-cycle grant latency).
REQ-021 In GRANTN, out_data/empty/sop/eop/valid SHALL equal inN_* combinationally, out_channel SHALL be N, inN_ready SHALL equal out_ready, and the other input's ready SHALL be 0.
REQ-022 A transfer SHALL be a cycle with out_valid && out_ready.
REQ-023 A transfer with out_endofpacket=1 in GRANTN SHALL move state to IDLE, set last_grant to N and increment pkt_cntN.
REQ-024 A single-word packet (sop and eop together) SHALL complete in one GRANT cycle and return to IDLE.
REQ-025 A sop received mid-packet in GRANTN SHALL be forwarded unchanged; only eop ends the grant.
REQ-026 inN_valid low in GRANTN SHALL hold the grant indefinitely; there is no timeout.
REQ-027 In IDLE, inN_ready SHALL be 1 when inN_valid=1 and inN_startofpacket=0, discarding that word and incrementing err_cnt.
REQ-028 err_cnt SHALL saturate at all-ones; it increments by 2 when both inputs discard in the same cycle, saturating.
REQ-029 pkt_cnt0/pkt_cnt1 SHALL wrap from all-ones to 0.
REQ-030 In IDLE, a requesting input (valid with sop) SHALL see ready=0.
REQ-031 out_channel SHALL be 0 in IDLE.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, last_grant=1, pkt_cnt0=pkt_cnt1=0, err_cnt=0.
REQ-033 During and after reset until the next grant: out_valid=0, in0_ready=in1_ready=0 (except discards per REQ-027 after release), out_channel=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; no eop is generated and no counter increments.

Verification
REQ-035 Bench SHALL cover: 3-word packet on in0 only, out_ready=1 -> grant at cycle 1, words at cycles 1-3, IDLE at cycle 4, pkt_cnt0=1.
REQ-036 Bench SHALL cover: both inputs request at once from reset -> in0 packet first, then in1 packet, then in0 wins the next tie; out_channel follows 0,1,0.
REQ-037 Bench SHALL cover: out_ready toggling 1,0,1,0 during a 4-word packet -> no word lost or duplicated, and the other input's ready stays 0 throughout.
REQ-038 Bench SHALL cover: in1 presents 3 words without sop while IDLE -> all three are accepted and dropped, out_valid=0, err_cnt=3; 300 such words -> err_cnt=255.
REQ-039 Bench SHALL cover: single-word sop+eop packets alternating on both inputs -> each completes in one grant cycle; pkt_cnt0 wraps to 0 after 65536 packets.
REQ-040 Bench SHALL cover: rst pulsed after the 2nd word of a 5-word packet -> state IDLE, out_valid=0 next cycle, counters 0, and a following fresh packet is forwarded correctly.
